// File: rtl/serial_sub_4.sv
// serial_sub_4 -- bit-serial subtractor, Diff = A - B - Bin (mod 2^WIDTH),
// one bit per clock, LSB first, with a Start/Busy/Done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2), default 4
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst_n  in   asynchronous active-low reset
//   Start  in   request; sampled only in IDLE
//   A      in   minuend, captured on accepted Start
//   B      in   subtrahend, captured on accepted Start
//   Bin    in   borrow-in, captured on accepted Start
//   Busy   out  high while the bits are being processed (RUN)
//   Done   out  one-cycle pulse; Diff/Bout (and Ovf) valid
//   Ovf    out  signed overflow of A - B - Bin (only with SERIAL_SUB_OVF_EN)
//   Diff   out  registered result, held until the next completion
//   Bout   out  registered borrow-out, 1 when A < B + Bin (unsigned)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the Ovf output.

module serial_sub_4 #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  // Only WIDTH-1 result bits need storing; the final bit goes straight
  // into Diff together with the accumulated ones.
  logic [WIDTH-2:0] res;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] full;

  always_comb begin
    d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    full   = {d_bit, res};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      Ovf   <= 1'b0;
`endif
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          res  <= full[WIDTH-1:1];
          if (cnt == CW'(WIDTH - 1)) begin
            Diff  <= full;
            Bout  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB while bit WIDTH-1 is processed
            Ovf   <= br ^ br_nxt;
`endif
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_4.sv
// tb_serial_sub_4 -- directed testbench for serial_sub_4 (WIDTH=4).
// Outputs are sampled on the falling clock edge; inputs change at the
// falling edge as well. Ovf checks are present only with SERIAL_SUB_OVF_EN.

module tb_serial_sub_4;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       Busy;
  logic       Done;
`ifdef SERIAL_SUB_OVF_EN
  logic       Ovf;
`endif
  logic [3:0] Diff;
  logic       Bout;

  int pass_cnt = 0;
  int total    = 0;

  serial_sub_4 #(.WIDTH(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf   (Ovf),
`endif
    .Diff  (Diff),
    .Bout  (Bout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Present a one-cycle Start pulse accepted at the next rising edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bin);
    @(negedge Clk);
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #2;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else pass_cnt++;
    total++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else pass_cnt++;
    total++; if (Diff !== 4'h0) $display("FAIL reset_diff got %h want 0", Diff); else pass_cnt++;
    total++; if (Bout !== 1'b0) $display("FAIL reset_bout got %b want 0", Bout); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total++; if (Ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", Ovf); else pass_cnt++;
`endif
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    start_op(4'd9, 4'd5, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (Done) begin
        done_n++; done_at = k;
        total++; if (Diff !== 4'd4) $display("FAIL basic_diff got %0d want 4", Diff); else pass_cnt++;
        total++; if (Bout !== 1'b0) $display("FAIL basic_bout got %b want 0", Bout); else pass_cnt++;
      end
    end
    total++; if (busy_n !== 4) $display("FAIL basic_busy_cycles got %0d want 4", busy_n); else pass_cnt++;
    total++; if (done_n !== 1) $display("FAIL basic_done_count got %0d want 1", done_n); else pass_cnt++;
    total++; if (done_at !== 5) $display("FAIL basic_latency got %0d want 5", done_at); else pass_cnt++;
    total++; if (Diff !== 4'd4) $display("FAIL basic_hold got %0d want 4", Diff); else pass_cnt++;
  endtask

  task automatic test_borrow;
    // A, B, Bin, Diff, Bout, Ovf
    logic [3:0] va [3] = '{4'd4, 4'd9, 4'd7};
    logic [3:0] vb [3] = '{4'd5, 4'd9, 4'd8};
    logic       vc [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] vd [3] = '{4'hE, 4'hF, 4'hF};
    logic       vo [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], vc[i]);
      // Inputs change right after capture and must not matter.
      A = 4'hA; B = 4'h3; Bin = ~vc[i];
      repeat (5) @(negedge Clk);
      total++; if (Done !== 1'b1) $display("FAIL borrow_done[%0d] got %b want 1", i, Done); else pass_cnt++;
      total++; if (Diff !== vd[i]) $display("FAIL borrow_diff[%0d] got %h want %h", i, Diff, vd[i]); else pass_cnt++;
      total++; if (Bout !== 1'b1) $display("FAIL borrow_bout[%0d] got %b want 1", i, Bout); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
      total++; if (Ovf !== vo[i]) $display("FAIL borrow_ovf[%0d] got %b want %b", i, Ovf, vo[i]); else pass_cnt++;
`else
      if (vo[i] === 1'bx) $display("unexpected table entry %0d", i);
`endif
    end
  endtask

  task automatic test_ignore_start;
    int done_n;
    done_n = 0;
    start_op(4'd9, 4'd5, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    A = 4'd0; B = 4'd1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Done) begin
        done_n++;
        total++; if (Diff !== 4'd4) $display("FAIL ignore_diff got %0d want 4", Diff); else pass_cnt++;
      end
    end
    total++; if (done_n !== 1) $display("FAIL ignore_done_count got %0d want 1", done_n); else pass_cnt++;
    total++; if (Busy !== 1'b0) $display("FAIL ignore_idle_busy got %b want 0", Busy); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int done_n, busy_n;
    done_n = 0; busy_n = 0;
    start_op(4'd9, 4'd5, 1'b0);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    total++; if (Busy !== 1'b0) $display("FAIL areset_busy got %b want 0", Busy); else pass_cnt++;
    total++; if (Done !== 1'b0) $display("FAIL areset_done got %b want 0", Done); else pass_cnt++;
    total++; if (Diff !== 4'd0) $display("FAIL areset_diff got %0d want 0", Diff); else pass_cnt++;
    total++; if (Bout !== 1'b0) $display("FAIL areset_bout got %b want 0", Bout); else pass_cnt++;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Done) done_n++;
      if (Busy) busy_n++;
    end
    total++; if (done_n !== 0) $display("FAIL areset_no_done got %0d want 0", done_n); else pass_cnt++;
    total++; if (busy_n !== 0) $display("FAIL areset_no_busy got %0d want 0", busy_n); else pass_cnt++;
    start_op(4'd6, 4'd2, 1'b0);
    repeat (5) @(negedge Clk);
    total++; if (Done !== 1'b1) $display("FAIL areset_new_done got %b want 1", Done); else pass_cnt++;
    total++; if (Diff !== 4'd4) $display("FAIL areset_new_diff got %0d want 4", Diff); else pass_cnt++;
    total++; if (Bout !== 1'b0) $display("FAIL areset_new_bout got %b want 0", Bout); else pass_cnt++;
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    int done_n, both_hi, bad_diff, bad_gap, last_at;
    done_n = 0; both_hi = 0; bad_diff = 0; bad_gap = 0; last_at = 0;
    @(negedge Clk);
    A = 4'd3; B = 4'd1; Bin = 1'b0; Start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Busy && Done) both_hi++;
      if (Done) begin
        done_n++;
        if (Diff !== 4'd2) bad_diff++;
        if (last_at == 0 && k != 5) bad_gap++;
        if (last_at != 0 && k - last_at != 6) bad_gap++;
        last_at = k;
      end
    end
    Start = 1'b0;
    total++; if (done_n !== 3) $display("FAIL b2b_done_count got %0d want 3", done_n); else pass_cnt++;
    total++; if (both_hi !== 0) $display("FAIL b2b_busy_done_overlap got %0d want 0", both_hi); else pass_cnt++;
    total++; if (bad_diff !== 0) $display("FAIL b2b_diff_errors got %0d want 0", bad_diff); else pass_cnt++;
    total++; if (bad_gap !== 0) $display("FAIL b2b_spacing_errors got %0d want 0", bad_gap); else pass_cnt++;
    repeat (8) @(negedge Clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_ignore_start;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout got no finish want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
